// File: rtl/dmem_port_arbiter.sv
// Data-memory port arbiter between the CPU load/store path and the UART loader.
// Optional starvation guard: define ARB_STARVE_GUARD_EN.
module dmem_port_arbiter #(
   parameter int ADDR_W       = 14,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = 8
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              boot_mode,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_stall,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic              ldr_gnt,
   output logic              ldr_rvalid,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [1:0]        owner,
   output logic [15:0]       ldr_words
);

   typedef enum logic [1:0] {
      NORMAL = 2'd0,
      BOOT   = 2'd1,
      DRAIN  = 2'd2
   } state_t;

   state_t state;
   logic   boot_q;
   logic   cpu_sel;
   logic   ldr_sel;
   logic   force_gnt;
   logic   boot_entry;

`ifdef ARB_STARVE_GUARD_EN
   localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

   logic [CNT_W-1:0] starve_cnt;

   assign force_gnt = (state == NORMAL) & ldr_req
                    & (starve_cnt == CNT_W'(STARVE_LIMIT));

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         starve_cnt <= '0;
      end else if (!ldr_req || ldr_sel) begin
         starve_cnt <= '0;
      end else if (state == NORMAL &&
                   starve_cnt != CNT_W'(STARVE_LIMIT)) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end
`else
   logic unused_starve_limit;

   assign unused_starve_limit = |STARVE_LIMIT;
   assign force_gnt = 1'b0;
`endif

   // Nothing is routed while reset is asserted.
   always_comb begin
      cpu_sel   = 1'b0;
      ldr_sel   = 1'b0;
      cpu_stall = 1'b0;
      if (!rst) begin
         case (state)
            NORMAL: begin
               if (force_gnt) begin
                  ldr_sel   = 1'b1;
                  cpu_stall = 1'b1;
               end else if (cpu_req) begin
                  cpu_sel = 1'b1;
               end else if (ldr_req) begin
                  ldr_sel = 1'b1;
               end
            end
            BOOT: begin
               cpu_stall = 1'b1;
               ldr_sel   = ldr_req;
            end
            DRAIN: begin
               cpu_stall = 1'b1;
            end
            default: begin
               cpu_stall = 1'b1;
            end
         endcase
      end
   end

   assign ldr_gnt   = ldr_sel;
   assign owner     = {ldr_sel, cpu_sel};
   assign mem_we    = ldr_sel ? ldr_we : (cpu_sel & cpu_we);
   assign mem_addr  = ldr_sel ? ldr_addr : cpu_addr;
   assign mem_wdata = ldr_sel ? ldr_wdata : cpu_wdata;
   assign cpu_rdata = mem_rdata;
   assign ldr_rdata = mem_rdata;

   assign boot_entry = (state != BOOT) & boot_q;

   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state      <= NORMAL;
         boot_q     <= 1'b0;
         ldr_rvalid <= 1'b0;
         ldr_words  <= 16'h0000;
      end else begin
         boot_q     <= boot_mode;
         ldr_rvalid <= ldr_sel & ~ldr_we;
         case (state)
            NORMAL:  if (boot_q) state <= BOOT;
            BOOT:    if (!boot_q) state <= DRAIN;
            DRAIN:   state <= boot_q ? BOOT : NORMAL;
            default: state <= NORMAL;
         endcase
         if (boot_entry) begin
            ldr_words <= 16'h0000;
         end else if (ldr_sel && ldr_we && ldr_words != 16'hFFFF) begin
            ldr_words <= ldr_words + 16'h0001;
         end
      end
   end

endmodule
